control_unit: RTL and testbench



---
 rtl/k_and_s_pkg.sv | 25 ++
 rtl/control_unit_if.sv | 32 +++
 rtl/control_unit.sv | 164 ++++++++++++++++
 tb/tb_control_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// Shared K&S processor types: instruction decode seen by the control unit.
package k_and_s_pkg;

    localparam int unsigned ALU_OP_W = 2;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_BOV    = 4'd13,
        I_BNOV   = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;

endpackage

// File: rtl/control_unit_if.sv
// Control unit <-> data_path link: decode and flags in, control strobes out.
interface control_unit_if;

    k_and_s_pkg::decoded_instruction_type decoded_instruction;
    logic                                 zero_op;
    logic                                 neg_op;
    logic                                 unsigned_overflow;
    logic                                 signed_overflow;

    logic                                 branch;
    logic                                 pc_enable;
    logic                                 ir_enable;
    logic                                 addr_sel;
    logic                                 c_sel;
    logic [k_and_s_pkg::ALU_OP_W-1:0]     operation;
    logic                                 write_reg_enable;
    logic                                 flags_reg_enable;
    logic                                 ram_write_enable;

    modport master (
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, ram_write_enable
    );

    modport slave (
        output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, ram_write_enable
    );

endinterface

// File: rtl/control_unit.sv
// K&S 16-bit processor control FSM: fetch/decode/execute sequencing and
// a saturating retired-instruction counter.
module control_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    control_unit_if.master    bus,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);
    import k_and_s_pkg::*;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_LOAD_A = 4'd2,
        S_LOAD_B = 4'd3,
        S_STORE  = 4'd4,
        S_MOVE   = 4'd5,
        S_ALU    = 4'd6,
        S_BRANCH = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   count_q;
    logic               retire_c;
    logic               taken_c;
    logic [ALU_OP_W-1:0] alu_op_c;

    // State register and saturating retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            count_q <= '0;
        end else begin
            state <= state_nxt;
            if (retire_c && (count_q != CNT_MAX)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Branch condition from the registered flags
    always_comb begin
        taken_c = 1'b0;
        case (bus.decoded_instruction)
            I_BRANCH: taken_c = 1'b1;
            I_BZERO:  taken_c = bus.zero_op;
            I_BNZERO: taken_c = !bus.zero_op;
            I_BNEG:   taken_c = bus.neg_op;
            I_BNNEG:  taken_c = !bus.neg_op;
            I_BOV:    taken_c = bus.signed_overflow | bus.unsigned_overflow;
            I_BNOV:   taken_c = !(bus.signed_overflow | bus.unsigned_overflow);
            default:  taken_c = 1'b0;
        endcase
    end

    // ALU opcode for arithmetic/logic instructions
    always_comb begin
        alu_op_c = 2'b00;
        case (bus.decoded_instruction)
            I_ADD:   alu_op_c = 2'b00;
            I_AND:   alu_op_c = 2'b01;
            I_OR:    alu_op_c = 2'b10;
            I_SUB:   alu_op_c = 2'b11;
            default: alu_op_c = 2'b00;
        endcase
    end

    // Next state and control strobes; everything held low during reset
    always_comb begin
        state_nxt            = state;
        retire_c             = 1'b0;
        bus.branch           = 1'b0;
        bus.pc_enable        = 1'b0;
        bus.ir_enable        = 1'b0;
        bus.addr_sel         = 1'b0;
        bus.c_sel            = 1'b0;
        bus.operation        = 2'b00;
        bus.write_reg_enable = 1'b0;
        bus.flags_reg_enable = 1'b0;
        bus.ram_write_enable = 1'b0;
        halted               = 1'b0;

        if (!rst) begin
            case (state)
                S_FETCH: begin
                    bus.ir_enable = 1'b1;
                    state_nxt     = S_DECODE;
                end
                S_DECODE: begin
                    bus.pc_enable = 1'b1;
                    case (bus.decoded_instruction)
                        I_LOAD:  state_nxt = S_LOAD_A;
                        I_STORE: state_nxt = S_STORE;
                        I_MOVE:  state_nxt = S_MOVE;
                        I_ADD, I_SUB, I_AND, I_OR: state_nxt = S_ALU;
                        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
                        I_BNNEG, I_BOV, I_BNOV:    state_nxt = S_BRANCH;
                        I_HALT:  state_nxt = S_HALT;
                        default: begin
                            state_nxt = S_FETCH;
                            retire_c  = 1'b1;
                        end
                    endcase
                end
                S_LOAD_A: begin
                    bus.addr_sel = 1'b1;
                    state_nxt    = S_LOAD_B;
                end
                S_LOAD_B: begin
                    bus.addr_sel         = 1'b1;
                    bus.c_sel            = 1'b1;
                    bus.write_reg_enable = 1'b1;
                    retire_c             = 1'b1;
                    state_nxt            = S_FETCH;
                end
                S_STORE: begin
                    bus.addr_sel         = 1'b1;
                    bus.ram_write_enable = 1'b1;
                    retire_c             = 1'b1;
                    state_nxt            = S_FETCH;
                end
                S_MOVE: begin
                    // a|a with both read ports on the source register
                    bus.operation        = 2'b10;
                    bus.write_reg_enable = 1'b1;
                    retire_c             = 1'b1;
                    state_nxt            = S_FETCH;
                end
                S_ALU: begin
                    bus.operation        = alu_op_c;
                    bus.write_reg_enable = 1'b1;
                    bus.flags_reg_enable = 1'b1;
                    retire_c             = 1'b1;
                    state_nxt            = S_FETCH;
                end
                S_BRANCH: begin
                    bus.pc_enable = taken_c;
                    bus.branch    = taken_c;
                    retire_c      = 1'b1;
                    state_nxt     = S_FETCH;
                end
                S_HALT: begin
                    halted    = 1'b1;
                    state_nxt = S_HALT;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    assign instr_count = rst ? '0 : count_q;

    // IR load, register write and RAM write are mutually exclusive
    a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
        $onehot0({bus.ir_enable, bus.write_reg_enable, bus.ram_write_enable}));

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-instruction cycle schedule model
// compared every cycle, plus hand-computed literal spot checks.
module tb_control_unit;
    import k_and_s_pkg::*;

    localparam int unsigned CNT_W   = 3;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    control_unit_if bus();

    control_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             branch;
        logic             pc_enable;
        logic             ir_enable;
        logic             addr_sel;
        logic             c_sel;
        logic [1:0]       operation;
        logic             wre;
        logic             fre;
        logic             rwe;
        logic             halted;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total   = 0;
    int   bad     = 0;
    int   retired = 0;
    int   cyc     = 0;

    // Expected record for a quiet cycle, carrying the modelled retire count
    function automatic exp_t blank();
        exp_t e = '0;
        e.cnt = CNT_W'((retired > CNT_MAX) ? CNT_MAX : retired);
        return e;
    endfunction

    // Per-cycle comparison against the queued schedule
    always @(negedge clk) begin
        exp_t act;
        exp_t e;
        act.branch    = bus.branch;
        act.pc_enable = bus.pc_enable;
        act.ir_enable = bus.ir_enable;
        act.addr_sel  = bus.addr_sel;
        act.c_sel     = bus.c_sel;
        act.operation = bus.operation;
        act.wre       = bus.write_reg_enable;
        act.fre       = bus.flags_reg_enable;
        act.rwe       = bus.ram_write_enable;
        act.halted    = halted;
        act.cnt       = instr_count;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL cycle%0d outputs act=%b exp=%b (br,pc,ir,as,cs,op,wr,fr,rw,h,cnt)",
                         cyc, act, e);
            end
        end
        cyc++;
    end

    task automatic lit(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int k);
        repeat (k) tick();
    endtask

    task automatic push_fd();
        exp_t e;
        e = blank(); e.ir_enable = 1'b1; q.push_back(e);
        e = blank(); e.pc_enable = 1'b1; q.push_back(e);
    endtask

    // Drive one instruction and queue its expected cycle schedule
    task automatic begin_instr(input decoded_instruction_type ins,
                               input logic z, input logic n, input logic uo, input logic so,
                               input int halt_cycles, output int len);
        exp_t e;
        logic tk;
        bit   ret;
        bus.decoded_instruction = ins;
        bus.zero_op             = z;
        bus.neg_op              = n;
        bus.unsigned_overflow   = uo;
        bus.signed_overflow     = so;
        push_fd();
        len = 2;
        ret = 1'b1;
        e   = blank();
        case (ins)
            I_LOAD: begin
                e.addr_sel = 1'b1; q.push_back(e);
                e.c_sel = 1'b1; e.wre = 1'b1; q.push_back(e);
                len = 4;
            end
            I_STORE: begin
                e.addr_sel = 1'b1; e.rwe = 1'b1; q.push_back(e); len = 3;
            end
            I_MOVE: begin
                e.operation = 2'b10; e.wre = 1'b1; q.push_back(e); len = 3;
            end
            I_ADD, I_AND, I_OR, I_SUB: begin
                case (ins)
                    I_AND:   e.operation = 2'b01;
                    I_OR:    e.operation = 2'b10;
                    I_SUB:   e.operation = 2'b11;
                    default: e.operation = 2'b00;
                endcase
                e.wre = 1'b1; e.fre = 1'b1; q.push_back(e); len = 3;
            end
            I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
                case (ins)
                    I_BRANCH: tk = 1'b1;
                    I_BZERO:  tk = z;
                    I_BNZERO: tk = !z;
                    I_BNEG:   tk = n;
                    I_BNNEG:  tk = !n;
                    I_BOV:    tk = so | uo;
                    default:  tk = !(so | uo);
                endcase
                e.pc_enable = tk; e.branch = tk; q.push_back(e); len = 3;
            end
            I_HALT: begin
                for (int i = 0; i < halt_cycles; i++) begin
                    e = blank(); e.halted = 1'b1; q.push_back(e);
                end
                len = 2 + halt_cycles;
                ret = 1'b0;
            end
            default: ;
        endcase
        if (ret) retired++;
    endtask

    task automatic run(input decoded_instruction_type ins,
                       input logic z, input logic n, input logic uo, input logic so);
        int len;
        begin_instr(ins, z, n, uo, so, 0, len);
        step(len);
    endtask

    task automatic do_reset(input int k);
        rst = 1'b1;
        repeat (k) begin
            q.push_back('0);
            tick();
        end
        rst     = 1'b0;
        retired = 0;
    endtask

    initial begin
        int len;
        rst                     = 1'b1;
        bus.decoded_instruction = I_NOP;
        bus.zero_op             = 1'b0;
        bus.neg_op              = 1'b0;
        bus.unsigned_overflow   = 1'b0;
        bus.signed_overflow     = 1'b0;
        @(posedge clk);
        #1;

        // Reset cycle: FETCH state but all strobes held low
        q.push_back('0);
        @(negedge clk);
        lit("rst_ir_enable", int'(bus.ir_enable), 0);
        lit("rst_halted", int'(halted), 0);
        lit("rst_count", int'(instr_count), 0);
        tick();
        rst     = 1'b0;
        retired = 0;

        // NOP stream
        begin_instr(I_NOP, 0, 0, 0, 0, 0, len);
        @(negedge clk);
        lit("nop_fetch_ir", int'(bus.ir_enable), 1);
        step(len);
        run(I_NOP, 0, 0, 0, 0);

        // LOAD timing
        begin_instr(I_LOAD, 0, 0, 0, 0, 0, len);
        @(negedge clk);
        lit("count_after_2nop", int'(instr_count), 2);
        step(2);
        @(negedge clk);
        lit("load_c3_addr_sel", int'(bus.addr_sel), 1);
        tick();
        @(negedge clk);
        lit("load_c4_wre", int'(bus.write_reg_enable), 1);
        lit("load_c4_c_sel", int'(bus.c_sel), 1);
        tick();

        // ALU ops and MOVE
        begin_instr(I_SUB, 0, 0, 0, 0, 0, len);
        step(2);
        @(negedge clk);
        lit("sub_op", int'(bus.operation), 3);
        lit("sub_fre", int'(bus.flags_reg_enable), 1);
        tick();
        begin_instr(I_ADD, 0, 0, 0, 0, 0, len);
        step(2);
        @(negedge clk);
        lit("add_op", int'(bus.operation), 0);
        tick();
        run(I_AND, 0, 0, 0, 0);
        run(I_OR, 0, 0, 0, 0);
        begin_instr(I_MOVE, 0, 0, 0, 0, 0, len);
        step(2);
        @(negedge clk);
        lit("move_op", int'(bus.operation), 2);
        lit("move_fre", int'(bus.flags_reg_enable), 0);
        tick();
        run(I_STORE, 0, 0, 0, 0);

        // Branches
        do_reset(1);
        begin_instr(I_BZERO, 1, 0, 0, 0, 0, len);
        step(2);
        @(negedge clk);
        lit("bzero_taken_pc", int'(bus.pc_enable), 1);
        lit("bzero_taken_branch", int'(bus.branch), 1);
        tick();
        begin_instr(I_BZERO, 0, 0, 0, 0, 0, len);
        step(2);
        @(negedge clk);
        lit("bzero_not_taken_pc", int'(bus.pc_enable), 0);
        tick();
        begin_instr(I_BNOV, 0, 0, 1, 0, 0, len);
        step(2);
        @(negedge clk);
        lit("bnov_uo_pc", int'(bus.pc_enable), 0);
        tick();
        run(I_BRANCH, 0, 0, 0, 0);
        run(I_BNZERO, 0, 0, 0, 0);
        run(I_BNZERO, 1, 0, 0, 0);
        run(I_BNEG, 0, 1, 0, 0);
        run(I_BNNEG, 0, 1, 0, 0);
        run(I_BOV, 0, 0, 0, 1);
        run(I_BNOV, 1, 1, 0, 0);

        // HALT holds until reset
        begin_instr(I_HALT, 0, 0, 0, 0, 100, len);
        step(2);
        @(negedge clk);
        lit("halt_c3", int'(halted), 1);
        step(len - 3);
        @(negedge clk);
        lit("halt_last", int'(halted), 1);
        lit("halt_last_pc", int'(bus.pc_enable), 0);
        tick();
        do_reset(1);
        begin_instr(I_NOP, 0, 0, 0, 0, 0, len);
        @(negedge clk);
        lit("post_halt_ir", int'(bus.ir_enable), 1);
        lit("post_halt_halted", int'(halted), 0);
        step(len);

        // Saturation at 2^CNT_W-1
        do_reset(1);
        for (int i = 0; i < 10; i++) run(I_NOP, 0, 0, 0, 0);
        begin_instr(I_STORE, 0, 0, 0, 0, 0, len);
        @(negedge clk);
        lit("count_saturated", int'(instr_count), 7);
        step(len);

        // Reset during LOAD_A abandons the load
        bus.decoded_instruction = I_LOAD;
        push_fd();
        step(2);
        do_reset(1);
        begin_instr(I_NOP, 0, 0, 0, 0, 0, len);
        @(negedge clk);
        lit("midrst_fetch_ir", int'(bus.ir_enable), 1);
        lit("midrst_count", int'(instr_count), 0);
        lit("midrst_wre", int'(bus.write_reg_enable), 0);
        step(len);

        lit("schedule_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
